// File: rtl/shift_sipo_pkg.sv
// Shared definitions for the serial-in / parallel-out shift register family.
//
// Contents:
//   DEFAULT_WIDTH  - default parallel word width
//   count_width()  - width of a counter that must hold values 0..w
package shift_sipo_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Bits needed to represent 0..w inclusive (the count saturates at w).
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_phase_counter.sv
// Free-running mod-WIDTH phase counter with a wrap indicator.
//
// Ports:
//   clk  - clock, rising-edge
//   rst  - synchronous active-high reset, forces phase to 0
//   wrap - high while phase == WIDTH-1, i.e. the next edge wraps to 0
module sipo_phase_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    output logic wrap
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

    logic [PW-1:0] phase_reg;
    logic [PW-1:0] phase_next;

    always_comb begin
        phase_next = phase_reg + 1'b1;
        if (phase_reg == LAST) begin
            phase_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_next;
        end
    end

    assign wrap = (phase_reg == LAST);

endmodule

// File: rtl/shift_sipo.sv
// Serial-in / parallel-out shift register with fill count and word strobe.
//
// Ports:
//   clk         - clock, everything updates on the rising edge
//   rst         - synchronous active-high reset
//   in          - serial data bit, sampled every edge (no enable)
//   q           - parallel register contents
//   sout        - bit pushed out of the far end on the most recent edge
//   count       - bits shifted in since reset, saturating at WIDTH
//   full        - count == WIDTH
//   word_strobe - one-cycle pulse after every WIDTH-th shift since reset
module shift_sipo
    import shift_sipo_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit SHIFT_LEFT = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in,
    output logic [WIDTH-1:0]                q,
    output logic                            sout,
    output logic [count_width(WIDTH)-1:0]   count,
    output logic                            full,
    output logic                            word_strobe
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_reg;
    logic             sout_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             full_reg;
    logic             word_strobe_reg;
    logic             phase_wrap;

    // Shift datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg    <= '0;
            sout_reg <= 1'b0;
        end else if (SHIFT_LEFT) begin
            q_reg    <= {q_reg[WIDTH-2:0], in};
            sout_reg <= q_reg[WIDTH-1];
        end else begin
            q_reg    <= {in, q_reg[WIDTH-1:1]};
            sout_reg <= q_reg[0];
        end
    end

    sipo_phase_counter #(
        .WIDTH (WIDTH)
    ) u_phase (
        .clk  (clk),
        .rst  (rst),
        .wrap (phase_wrap)
    );

    always_comb begin
        count_next = count_reg;
        if (count_reg != COUNT_MAX) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Fill counter, full flag and word strobe. full is computed from
    // count_next so it lines up with the count value it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg       <= '0;
            full_reg        <= 1'b0;
            word_strobe_reg <= 1'b0;
        end else begin
            count_reg       <= count_next;
            full_reg        <= (count_next == COUNT_MAX);
            word_strobe_reg <= phase_wrap;
        end
    end

    assign q           = q_reg;
    assign sout        = sout_reg;
    assign count       = count_reg;
    assign full        = full_reg;
    assign word_strobe = word_strobe_reg;

endmodule

// File: tb/tb_shift_sipo.sv
module tb_shift_sipo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;

    always #5 clk = ~clk;

    // Three configurations share the same stimulus.
    logic [3:0] a_q;  logic a_sout; logic [2:0] a_count; logic a_full; logic a_ws;
    logic [3:0] b_q;  logic b_sout; logic [2:0] b_count; logic b_full; logic b_ws;
    logic [7:0] c_q;  logic c_sout; logic [3:0] c_count; logic c_full; logic c_ws;

    shift_sipo #(.WIDTH(4), .SHIFT_LEFT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in(in), .q(a_q), .sout(a_sout),
        .count(a_count), .full(a_full), .word_strobe(a_ws));

    shift_sipo #(.WIDTH(4), .SHIFT_LEFT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in(in), .q(b_q), .sout(b_sout),
        .count(b_count), .full(b_full), .word_strobe(b_ws));

    shift_sipo #(.WIDTH(8), .SHIFT_LEFT(1'b1)) dut_c (
        .clk(clk), .rst(rst), .in(in), .q(c_q), .sout(c_sout),
        .count(c_count), .full(c_full), .word_strobe(c_ws));

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference: history of bits accepted since the last reset.
    int n_shift = 0;
    bit hist[$];
    int strobe_seen_c = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (shift %0d)", tag, got, exp, n_shift);
        end
    endtask

    // The i-th newest bit sits i places from the entry end of the register.
    function automatic logic [31:0] exp_q(input int w, input bit left);
        logic [31:0] v = '0;
        int avail = (n_shift < w) ? n_shift : w;
        for (int i = 0; i < avail; i++) begin
            if (left) v[i] = hist[n_shift-1-i];
            else      v[w-1-i] = hist[n_shift-1-i];
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_sout(input int w);
        return (n_shift > w) ? 32'(hist[n_shift-1-w]) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_count(input int w);
        return (n_shift < w) ? 32'(n_shift) : 32'(w);
    endfunction

    function automatic logic [31:0] exp_strobe(input int w);
        return (n_shift > 0 && (n_shift % w) == 0) ? 32'd1 : 32'd0;
    endfunction

    task automatic check_all();
        check_eq("a_q",     32'(a_q),     exp_q(4, 1'b1));
        check_eq("a_sout",  32'(a_sout),  exp_sout(4));
        check_eq("a_count", 32'(a_count), exp_count(4));
        check_eq("a_full",  32'(a_full),  32'(n_shift >= 4));
        check_eq("a_ws",    32'(a_ws),    exp_strobe(4));
        check_eq("b_q",     32'(b_q),     exp_q(4, 1'b0));
        check_eq("b_sout",  32'(b_sout),  exp_sout(4));
        check_eq("b_count", 32'(b_count), exp_count(4));
        check_eq("b_full",  32'(b_full),  32'(n_shift >= 4));
        check_eq("b_ws",    32'(b_ws),    exp_strobe(4));
        check_eq("c_q",     32'(c_q),     exp_q(8, 1'b1));
        check_eq("c_sout",  32'(c_sout),  exp_sout(8));
        check_eq("c_count", 32'(c_count), exp_count(8));
        check_eq("c_full",  32'(c_full),  32'(n_shift >= 8));
        check_eq("c_ws",    32'(c_ws),    exp_strobe(8));
    endtask

    // One clock edge with the given in/rst, then update the model and check.
    task automatic tick(input bit b, input bit r);
        in  = b;
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            n_shift = 0;
            hist.delete();
        end else begin
            hist.push_back(b);
            n_shift++;
        end
        if (c_ws) strobe_seen_c++;
        $display("edge rst=%0b in=%0b | a q=%b s=%0b c=%0d f=%0b w=%0b | b q=%b | c q=%b c=%0d w=%0b",
                 r, b, a_q, a_sout, a_count, a_full, a_ws, b_q, c_q, c_count, c_ws);
        check_all();
    endtask

    initial begin
        // Reset, then a run of zeros: count climbs, no strobe yet.
        tick(0, 1); tick(0, 1);
        tick(0, 0); tick(0, 0); tick(0, 0);
        check_eq("zeros_count", 32'(a_count), 32'd3);

        // 0 then four 1s then 0s: q fills with ones, sout follows later.
        tick(0, 1);
        tick(0, 0);
        for (int i = 0; i < 4; i++) tick(1, 0);
        check_eq("ones_q", 32'(a_q), 32'hF);
        tick(0, 0);
        check_eq("ones_sout6", 32'(a_sout), 32'd1);
        tick(0, 0);
        check_eq("ones_q7", 32'(a_q), 32'hC);

        // Pattern 1,0,1,1 then another word: strobes after edges 4 and 8.
        tick(0, 1);
        tick(1, 0); tick(0, 0); tick(1, 0); tick(1, 0);
        check_eq("pat_q", 32'(a_q), 32'hB);
        check_eq("pat_ws", 32'(a_ws), 32'd1);
        for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)), 0);

        // Right-shifting config with 1,0,0,0.
        tick(0, 1);
        tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 0);
        check_eq("right_q", 32'(b_q), 32'h1);

        // Reset mid-word: partial word discarded, strobe 4 edges later.
        tick(0, 1);
        tick(1, 0); tick(1, 0);
        tick(1, 1);
        for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)), 0);
        check_eq("midrst_ws", 32'(a_ws), 32'd1);

        // Long run on the wide config: strobes after 8 and 16 only.
        tick(0, 1);
        strobe_seen_c = 0;
        for (int i = 0; i < 20; i++) tick(1'($urandom_range(0, 1)), 0);
        check_eq("wide_count", 32'(c_count), 32'd8);
        check_eq("wide_strobes", 32'(strobe_seen_c), 32'd2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 200; i++) begin
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/shift_sipo.md
SHIFT_SIPO -- requirements
Module: shift_sipo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of bits in the parallel output register (legal range 2..32).
REQ-002 The block SHALL have parameter SHIFT_LEFT, default 1: 1 = new bit enters q[0] and bits move toward q[WIDTH-1]; 0 = new bit enters q[WIDTH-1] and bits move toward q[0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in  input  1  serial data bit, sampled on every rising clk edge.
REQ-006 q  output  WIDTH  parallel register contents.
REQ-007 sout  output  1  bit shifted out of the far end of the register on the most recent edge.
REQ-008 count  output  clog2(WIDTH+1)  number of bits shifted in since reset, saturating at WIDTH.
REQ-009 full  output  1  high when count equals WIDTH, meaning q holds WIDTH valid sampled bits.
REQ-010 word_strobe  output  1  one-cycle pulse every WIDTH shifts after reset, marking a freshly completed word in q.

Function
REQ-011 The block SHALL shift on every rising clk edge when rst is low; there is no enable.
REQ-012 With SHIFT_LEFT=1, the next q SHALL be {q[WIDTH-2:0], in}, and sout SHALL take the old q[WIDTH-1].
REQ-013 With SHIFT_LEFT=0, the next q SHALL be {in, q[WIDTH-1:1]}, and sout SHALL take the old q[0].
REQ-014 The latency from in sampled to appearing in q SHALL be one clock, and to appearing on sout SHALL be WIDTH+1 clocks.
REQ-015 count SHALL increment by 1 per shift until it reaches WIDTH, then hold at WIDTH.
REQ-016 full SHALL be a registered output equal to (count == WIDTH).
REQ-017 An internal phase counter SHALL run 0..WIDTH-1 and wrap to 0.
REQ-018 word_strobe SHALL be high for exactly the cycle following each edge on which the phase counter wraps from WIDTH-1 to 0, i.e. after shifts WIDTH, 2*WIDTH, and so on.
REQ-019 All outputs SHALL be registered, with no combinational path from in to any output.
REQ-020 If rst and a shift coincide on the same edge, reset SHALL win and no bit is captured.

Reset
REQ-021 On a rising clk edge with rst high, the block SHALL force q=0, sout=0, count=0, full=0, word_strobe=0, and the phase counter to 0.
REQ-022 Reset asserted mid-word SHALL discard the partial word, and the next word SHALL start at the first edge after rst deasserts.
REQ-023 Until the first reset, outputs are undefined; the bench SHALL reset the block before checking outputs.

Structure
REQ-024 A shared package SHALL hold the default WIDTH constant and a clog2-based count-width function for reuse by sibling shift blocks.
REQ-025 The shift datapath (q, sout) and the counter/strobe logic SHALL be separate always blocks in one module.
REQ-026 One sub-module is natural: sipo_phase_counter, a mod-WIDTH counter with wrap pulse.

Verification
REQ-027 Reset then in=0 for 3 clocks -> q=4'b0000, count=3, full=0, word_strobe never high.
REQ-028 Reset, then in=0 for 1 edge, then in=1 for 4 edges, then in=0 (WIDTH=4, SHIFT_LEFT=1):
- q steps 0001, 0011, 0111, 1111 on the 1-edges;
- then 1110, 1100 on the following 0-edges;
- sout shows 0 then 1 on the 6th edge.
REQ-029 Serial pattern 1,0,1,1 after reset -> q=4'b1011 after edge 4, full=1, and word_strobe high exactly one cycle after edge 4 and again one cycle after edge 8.
REQ-030 SHIFT_LEFT=0 with pattern 1,0,0,0 -> q=4'b0001 after edge 4.
REQ-031 rst asserted after edge 2 of a word -> q=0 and count=0 on the next edge, and the next word_strobe comes 4 edges after rst deasserts.
REQ-032 WIDTH=8 with 20 shifts -> count saturates at 8, and word_strobe pulses after shifts 8 and 16 only.
